axis_dwidth_down: RTL and testbench
===================================

# axis_dwidth_down

AXI-Stream width down-converter that consumes the wide beat stream from an `axis_flop_fifo` output and emits it as narrower chunks for narrow sinks, such as 64-bit CSR/descriptor or MAC-facing paths. Each accepted input beat is held in a one-beat register and issued as up to RATIO output chunks, lowest lane first. With the skip option compiled in, chunks whose keep slice is all zero are not issued. The block sits directly downstream of the flop FIFO stage, and that FIFO is its only required upstream.

## Interface
- IN_WIDTH, 512, input data width in bits.
- OUT_WIDTH, 64, output data width in bits. IN_WIDTH must be an integer multiple of OUT_WIDTH.
- IN_KEEP_WIDTH, IN_WIDTH/8, input keep width.
- OUT_KEEP_WIDTH, OUT_WIDTH/8, output keep width.
- RATIO, derived as IN_WIDTH/OUT_WIDTH; legal range 2..16.

Ports:
- aclk  in  1  clock. One clock only.
- sync_rst_n  in  1  reset, synchronous and active-low.
- s_axis_valid  in  1  input beat valid.
- s_axis_data  in  IN_WIDTH  input data.
- s_axis_keep  in  IN_KEEP_WIDTH  input byte enables.
- s_axis_last  in  1  input end of packet.
- s_axis_ready  out  1  input accept.
- m_axis_valid  out  1  output chunk valid.
- m_axis_data  out  OUT_WIDTH  output chunk; this is slice idx of the held data.
- m_axis_keep  out  OUT_KEEP_WIDTH  keep slice idx.
- m_axis_last  out  1  end of packet on the final chunk.
- m_axis_ready  in  1  output accept.

## Operation
- State:
  - `full`: hold register occupied.
  - `hold_data`, `hold_keep`, `hold_last`: the held beat.
  - `idx`: current chunk index, $clog2(RATIO) bits.
- States:
  - EMPTY (`full`=0).
  - SEND (`full`=1).
- Chunk i is non-empty when `hold_keep[i*OUT_KEEP_WIDTH +: OUT_KEEP_WIDTH]` != 0.
- `final` is true when no non-empty chunk has an index above `idx`.
- `s_axis_ready` = sync_rst_n & (~full | (m_axis_valid & m_axis_ready & final)).
- An input handshake loads the hold register and sets `full`.
  - `idx` loads to the lowest non-empty chunk index, or 0 if none.
- An output handshake with ~`final` moves `idx` to the next non-empty chunk above it.
- An output handshake with `final` and no simultaneous input handshake clears `full`.
- When both handshakes occur in the same cycle, the new beat is loaded and `full` stays 1.
- `m_axis_valid` = `full`.
- `m_axis_last` = `hold_last` & `final`.
- An input beat with all-zero keep:
  - last=1: issue a single chunk 0 with keep=0 and last=1, so the packet still terminates.
  - last=0: accept the beat and do not issue it. `full` is not set; the beat is consumed in one cycle.
- While `m_axis_valid` is high and `m_axis_ready` is low, `m_axis_data`, `m_axis_keep` and `m_axis_last` hold stable.
- Reset mid-beat discards the held beat. No chunk or last is emitted for it.

## Timing
- Reset values:
  - `m_axis_valid`=0, `m_axis_last`=0.
  - `m_axis_data` and `m_axis_keep` are slice 0 of the cleared hold register, which is 0.
  - `s_axis_ready`=0 while sync_rst_n=0.
  - `full`=0, `idx`=0.
- `s_axis_ready` is 1 in the first cycle after reset deasserts.
- Latency: the first chunk is valid on the cycle after the input handshake.
- Throughput: one chunk per cycle while `m_axis_ready` is high.
  - Back-to-back input beats produce no bubble, because the next beat is accepted in the same cycle as the previous beat's final chunk.
- `s_axis_ready` has a combinational path from `m_axis_ready`. This is permitted because the upstream is a registered flop FIFO.
- The output-side signals are driven only from registers through the idx mux. There is no combinational path from the s_axis inputs to m_axis.

## Configuration
- `AXIS_DWIDTH_DOWN_SKIP_EN` defined: empty-chunk skipping operates as described above.
- Not defined:
  - Every beat issues all RATIO chunks, 0..RATIO-1, including chunks whose keep slice is zero.
  - `final` means `idx`==RATIO-1, and `idx` loads to 0.
  - An all-zero-keep beat with last=0 also issues RATIO chunks.

## Test plan
All scenarios use the default parameters (RATIO=8).
- Scenario 1, full beat:
  - Stimulus: keep=all ones, last=1, `m_axis_ready`=1.
  - Response: 8 chunks on consecutive cycles, starting 1 cycle after accept, each with keep=8'hFF; last only on chunk 7; data slices in order.
- Scenario 2, back-to-back beats:
  - Stimulus: two beats with last=0 then last=1.
  - Response: 16 chunks with no idle cycle; `s_axis_ready`=1 exactly in the cycles of chunk 7 of beat 1 and chunk 7 of beat 2.
- Scenario 3, trailing empty chunks:
  - Stimulus: keep=64'h0000_0000_0000_FFFF, last=1.
  - Response with skip: 2 chunks, last on chunk 1.
  - Response without the macro: 8 chunks, chunks 2..7 with keep=0, last on chunk 7.
- Scenario 4, sparse and empty beats (skip enabled):
  - Stimulus: keep=64'hFF00_0000_0000_00FF with last=0, then keep=0 with last=1.
  - Response: chunks 0 and 7 with last=0, then one chunk with keep=0 and last=1.
- Scenario 5, backpressure:
  - Stimulus: `m_axis_ready` pattern 1,0,1,0 during a full beat.
  - Response: outputs stable on every ready=0 cycle; `s_axis_ready`=0 until the final chunk handshakes; 8 chunks in 16 cycles.
- Scenario 6, reset mid-beat:
  - Stimulus: sync_rst_n=0 for 2 cycles after chunk 2.
  - Response: `m_axis_valid`=0 on the cycle after reset is sampled; `s_axis_ready`=1 after release; the next beat starts at chunk 0 with no stale last.

Source files
------------

// File: rtl/axis_dwidth_down_if.sv
// AXI-Stream bundle shared by the wide input and narrow output of axis_dwidth_down.
// Handshake: a transfer happens on any rising clock edge where valid and ready are both 1; once valid rises, data/keep/last hold until that edge.
interface axis_dwidth_down_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  ready;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/axis_dwidth_down.sv
// AXI-Stream width down-converter: one wide beat is held and issued as narrow chunks, lowest lane first.
// Define AXIS_DWIDTH_DOWN_SKIP_EN to drop chunks whose keep slice is all zero.
module axis_dwidth_down #(
    parameter int IN_WIDTH       = 512,
    parameter int OUT_WIDTH      = 64,
    parameter int IN_KEEP_WIDTH  = IN_WIDTH / 8,
    parameter int OUT_KEEP_WIDTH = OUT_WIDTH / 8,
    localparam int RATIO         = IN_WIDTH / OUT_WIDTH,
    localparam int IDX_W         = $clog2(RATIO)
) (
    input  logic               aclk,
    input  logic               sync_rst_n,
    axis_dwidth_down_if.slave  s_axis,
    axis_dwidth_down_if.master m_axis,
    output logic               dbg_state,
    output logic [IDX_W-1:0]   dbg_idx
);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [IN_WIDTH-1:0]       hold_data;
    logic [IN_KEEP_WIDTH-1:0]  hold_keep;
    logic                      hold_last;

    logic                      full;
    logic                      is_final;
    logic [IDX_W-1:0]          next_idx;
    logic [IDX_W-1:0]          load_idx;
    logic                      load_full;
    logic                      in_hs;
    logic                      out_hs;

    assign full = (state == SEND);

`ifdef AXIS_DWIDTH_DOWN_SKIP_EN
    logic [RATIO-1:0] hold_nz;
    logic [RATIO-1:0] in_nz;

    always_comb begin
        for (int i = 0; i < RATIO; i++) begin
            hold_nz[i] = |hold_keep[i*OUT_KEEP_WIDTH +: OUT_KEEP_WIDTH];
            in_nz[i]   = |s_axis.keep[i*OUT_KEEP_WIDTH +: OUT_KEEP_WIDTH];
        end
    end

    // Scanning downwards leaves the lowest qualifying lane in each result.
    always_comb begin
        is_final = 1'b1;
        next_idx = idx;
        load_idx = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (hold_nz[i] && (i > int'(idx))) begin
                is_final = 1'b0;
                next_idx = IDX_W'(i);
            end
            if (in_nz[i]) begin
                load_idx = IDX_W'(i);
            end
        end
    end

    // An all-empty beat only occupies the register when it must carry last.
    assign load_full = (|in_nz) | s_axis.last;
`else
    assign is_final  = (idx == IDX_W'(RATIO - 1));
    assign next_idx  = idx + IDX_W'(1);
    assign load_idx  = '0;
    assign load_full = 1'b1;
`endif

    assign s_axis.ready = sync_rst_n & (~full | (m_axis.ready & is_final));
    assign in_hs        = s_axis.valid & s_axis.ready;
    assign out_hs       = full & m_axis.ready;

    always_ff @(posedge aclk) begin
        if (!sync_rst_n) begin
            state     <= EMPTY;
            idx       <= '0;
            hold_data <= '0;
            hold_keep <= '0;
            hold_last <= 1'b0;
        end else if (in_hs && load_full) begin
            state     <= SEND;
            idx       <= load_idx;
            hold_data <= s_axis.data;
            hold_keep <= s_axis.keep;
            hold_last <= s_axis.last;
        end else if (out_hs) begin
            // A dropped empty beat arriving here coincides with a final chunk, so EMPTY is right.
            if (is_final) begin
                state <= EMPTY;
                idx   <= '0;
            end else begin
                idx <= next_idx;
            end
        end
    end

    assign m_axis.valid = full;
    assign m_axis.data  = hold_data[int'(idx)*OUT_WIDTH +: OUT_WIDTH];
    assign m_axis.keep  = hold_keep[int'(idx)*OUT_KEEP_WIDTH +: OUT_KEEP_WIDTH];
    assign m_axis.last  = full & hold_last & is_final;

    assign dbg_state = state;
    assign dbg_idx   = idx;

endmodule

// File: tb/tb_axis_dwidth_down.sv
// Directed and randomized bench for axis_dwidth_down with a chunk-list reference model.
module tb_axis_dwidth_down;

  localparam int W = 64 + 8 + 1;
`ifdef AXIS_DWIDTH_DOWN_SKIP_EN
  localparam int S3_N = 2;
  localparam int S4_N = 3;
`else
  localparam int S3_N = 8;
  localparam int S4_N = 16;
`endif

  logic       aclk;
  logic       sync_rst_n;
  logic       dbg_state;
  logic [2:0] dbg_idx;

  axis_dwidth_down_if #(.DATA_WIDTH(512)) s_if ();
  axis_dwidth_down_if #(.DATA_WIDTH(64))  m_if ();

  axis_dwidth_down dut (
    .aclk       (aclk),
    .sync_rst_n (sync_rst_n),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .dbg_state  (dbg_state),
    .dbg_idx    (dbg_idx)
  );

  // clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  logic [W-1:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int mon_chk = 0;
  int mon_fail = 0;
  int vcnt = 0;
  int srdy_cnt = 0;
  int push_cnt = 0;
  int ready_mode = 0;

  // output ready driver: 0 = always, 1 = random, 2 = alternating
  initial begin
    m_if.ready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0: m_if.ready = 1'b1;
        1: m_if.ready = 1'($urandom_range(0, 1));
        default: m_if.ready = ~m_if.ready;
      endcase
    end
  end

  // scoreboard monitor
  initial begin
    logic         have_prev;
    logic [W-1:0] prev;
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    have_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge aclk);
      obs = {m_if.data, m_if.keep, m_if.last};
      if (!sync_rst_n) begin
        have_prev = 1'b0;
      end else begin
        mon_chk++;
        assert (m_if.valid === (exp_q.size() != 0)) else begin
          mon_fail++;
          $error("FAIL valid_vs_pending: observed %0b required %0b", m_if.valid, exp_q.size() != 0);
        end
        if (have_prev) begin
          mon_chk++;
          assert ((m_if.valid === 1'b1) && (obs === prev)) else begin
            mon_fail++;
            $error("FAIL stall_stable: observed %0h/%0b required %0h/1", obs, m_if.valid, prev);
          end
        end
        if (m_if.valid && m_if.ready) begin
          vcnt++;
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          mon_chk++;
          assert (obs === exp) else begin
            mon_fail++;
            $error("FAIL chunk: observed %0h required %0h", obs, exp);
          end
        end
        if (m_if.valid && s_if.ready) srdy_cnt++;
        have_prev = m_if.valid && !m_if.ready;
        prev = obs;
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // reference: chunk list a beat must produce
  task automatic model_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
`ifdef AXIS_DWIDTH_DOWN_SKIP_EN
    int hi;
    hi = -1;
    for (int i = 0; i < 8; i++) if (k[i*8 +: 8] != 8'h00) hi = i;
    if (hi < 0) begin
      if (l) begin
        exp_q.push_back({d[63:0], 8'h00, 1'b1});
        push_cnt++;
      end
    end else begin
      for (int i = 0; i <= hi; i++) begin
        if (k[i*8 +: 8] != 8'h00) begin
          exp_q.push_back({d[i*64 +: 64], k[i*8 +: 8], l && (i == hi)});
          push_cnt++;
        end
      end
    end
`else
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({d[i*64 +: 64], k[i*8 +: 8], l && (i == 7)});
      push_cnt++;
    end
`endif
  endtask

  // driver: call at posedge+1, returns at posedge+1 after the accept edge
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int n;
    n = 0;
    s_if.valid = 1'b1;
    s_if.data = d;
    s_if.keep = k;
    s_if.last = l;
    @(negedge aclk);
    while (!s_if.ready && n < 300) begin
      @(negedge aclk);
      n++;
    end
    chk("accept_timeout", 1'(n >= 300), 1'b0);
    @(posedge aclk);
    if (n < 300) model_beat(d, k, l);
    #1;
    s_if.valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge aclk);
    #1;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge aclk);
      #1;
      n++;
    end
    chk("drain", 512'(exp_q.size()), 512'd0);
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    int vb;
    int sb;
    int pb;
    int n;
    logic [511:0] d;
    logic [63:0]  k;

    s_if.valid = 1'b0;
    s_if.data = '0;
    s_if.keep = '0;
    s_if.last = 1'b0;
    sync_rst_n = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_valid", m_if.valid, 1'b0);
    chk("rst_m_last", m_if.last, 1'b0);
    chk("rst_m_data", m_if.data, 64'd0);
    chk("rst_m_keep", m_if.keep, 8'd0);
    chk("rst_s_ready", s_if.ready, 1'b0);
    chk("rst_state", dbg_state, 1'b0);
    chk("rst_idx", dbg_idx, 3'd0);
    @(posedge aclk);
    #1;
    sync_rst_n = 1'b1;
    @(negedge aclk);
    chk("ready_after_rst", s_if.ready, 1'b1);
    @(posedge aclk);
    #1;

    // scenario 1: full beat, one chunk per cycle from the next cycle
    vb = vcnt; sb = srdy_cnt;
    send_beat(rand_data(), '1, 1'b1);
    @(negedge aclk);
    chk("s1_latency_valid", m_if.valid, 1'b1);
    chk("s1_first_idx", dbg_idx, 3'd0);
    wait_drain();
    chk("s1_count", 512'(vcnt - vb), 512'd8);
    chk("s1_sready_hits", 512'(srdy_cnt - sb), 512'd1);
    @(posedge aclk); #1;

    // scenario 2: back-to-back beats
    vb = vcnt; sb = srdy_cnt;
    send_beat(rand_data(), '1, 1'b0);
    send_beat(rand_data(), '1, 1'b1);
    wait_drain();
    chk("s2_count", 512'(vcnt - vb), 512'd16);
    chk("s2_sready_hits", 512'(srdy_cnt - sb), 512'd2);
    @(posedge aclk); #1;

    // scenario 3: trailing empty chunks
    vb = vcnt;
    send_beat(rand_data(), 64'h0000_0000_0000_FFFF, 1'b1);
    wait_drain();
    chk("s3_count", 512'(vcnt - vb), 512'(S3_N));
    @(posedge aclk); #1;

    // scenario 4: sparse then empty beat
    vb = vcnt;
    send_beat(rand_data(), 64'hFF00_0000_0000_00FF, 1'b0);
    send_beat(rand_data(), 64'h0, 1'b1);
    wait_drain();
    chk("s4_count", 512'(vcnt - vb), 512'(S4_N));
    @(posedge aclk); #1;

    // scenario 5: alternating backpressure
    ready_mode = 2;
    vb = vcnt; sb = srdy_cnt;
    send_beat(rand_data(), '1, 1'b1);
    wait_drain();
    chk("s5_count", 512'(vcnt - vb), 512'd8);
    chk("s5_sready_hits", 512'(srdy_cnt - sb), 512'd1);
    ready_mode = 0;
    repeat (2) @(posedge aclk);
    #1;

    // scenario 6: reset after chunk 2
    vb = vcnt;
    send_beat(rand_data(), '1, 1'b1);
    n = 0;
    while ((vcnt - vb) < 3 && n < 100) begin
      @(negedge aclk);
      #1;
      n++;
    end
    chk("s6_reach_chunk2", 512'(vcnt - vb), 512'd3);
    @(posedge aclk);
    #1;
    sync_rst_n = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    @(negedge aclk);
    chk("s6_valid_in_rst", m_if.valid, 1'b0);
    chk("s6_last_in_rst", m_if.last, 1'b0);
    chk("s6_sready_in_rst", s_if.ready, 1'b0);
    @(posedge aclk);
    #1;
    sync_rst_n = 1'b1;
    @(negedge aclk);
    chk("s6_sready_release", s_if.ready, 1'b1);
    chk("s6_valid_release", m_if.valid, 1'b0);
    @(posedge aclk);
    #1;
    send_beat(rand_data(), 64'h00FF_00FF_00FF_00FF, 1'b1);
    @(negedge aclk);
    chk("s6_restart_idx", dbg_idx, 3'd0);
    wait_drain();
    @(posedge aclk); #1;

    // randomized beats under random backpressure
    ready_mode = 1;
    vb = vcnt;
    pb = push_cnt;
    for (int b = 0; b < 40; b++) begin
      d = rand_data();
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0: k[i*8 +: 8] = 8'h00;
          1: k[i*8 +: 8] = 8'hFF;
          default: k[i*8 +: 8] = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 7) == 0) k = '0;
      send_beat(d, k, 1'($urandom_range(0, 1)));
      n = $urandom_range(0, 2);
      if (n > 0) begin
        repeat (n) @(posedge aclk);
        #1;
      end
    end
    wait_drain();
    chk("rand_count", 512'(vcnt - vb), 512'(push_cnt - pb));

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk + mon_chk, n_fail + mon_fail);
    $finish;
  end

endmodule
